pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and flush controller for the pipelined WISC core. It replaces the fixed 5-stage forwarding and hazard-detection pair with a scoreboard of in-flight writers `DEPTH` stages deep. It generates decode stalls, ID/EX bubbles, IF/ID flushes and EX operand-forward selects, and freezes the whole pipe on multi-cycle memory (cache miss) busy. It sits beside the pipeline registers and is driven from decode.

Parameters:
REG_AW, 4, register index width (16 registers).
DEPTH, 3, tracked post-decode stages: 0=ID/EX, 1=EX/MEM, …, DEPTH-1=final writeback stage; legal range 2..8.
LOAD_READY, 2, first stage index at which load data can be forwarded; 1 <= LOAD_READY <= DEPTH-1.
R0_IS_ZERO, 1, when 1 register 0 never matches, stalls or forwards.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode holds a real instruction
id_src1 / id_src2  in  REG_AW each  decode source registers (store data is src2)
id_src1_used / id_src2_used  in  1 each  source is actually read
id_src_early  in  1  sources are consumed in ID (BR target, branch resolution)
id_dst  in  REG_AW  decode destination
id_regwrite  in  1  decode instruction writes a register
id_memread  in  1  decode instruction is LW
branch_taken  in  1  decode resolved a taken B/BR
mem_busy  in  1  imem or dmem not ready; freeze the pipe
stall_if_id  out  1  hold PC and IF/ID
bubble_id_ex  out  1  load a NOP into ID/EX
flush_if_id  out  1  squash the IF/ID instruction
fwd_sel1 / fwd_sel2  out  3 each  0 = register data; k = stage-k result
stall_cnt / freeze_cnt / flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Scoreboard entry per stage: valid, dst, regwrite, memread, src1, src2, src1_used, src2_used.
- Reset (async, rst_n low, including mid-operation): all entries invalid, counters 0.
- Every output is 0 during reset and in the cycle after reset.
- Clock edge with mem_busy=1: all entries hold and counters other than freeze_cnt hold.
- Clock edge with mem_busy=0:
  - entry[k] <= entry[k-1] for k >= 1.
  - entry[0] <= decoded fields if id_valid & ~stall_if_id, else an invalid entry (bubble).
- match(k,s) = entry[k].valid & regwrite & dst==s & ~(R0_IS_ZERO & s==0).
- For each used decode source s, find the youngest (smallest) k with match(k,s); older matches are ignored.
- Normal source stalls if entry[k].memread & (k+1 < LOAD_READY).
- Early source stalls if k < DEPTH-1; a stage-(DEPTH-1) writer is covered by register-file write-through, which the register file must provide.
- stall_if_id = id_valid & ~mem_busy & any source stall. This is combinational; it is held low while mem_busy=1.
- bubble_id_ex = stall_if_id.
- flush_if_id = branch_taken & ~stall_if_id & ~mem_busy. A branch that is stalled does not flush until it resolves.
- fwd_selN (combinational from entry[0]):
  - If entry[0].valid and srcN_used, fwd_selN = youngest k in 1..DEPTH-1 with match(k, entry[0].srcN).
  - Otherwise fwd_selN = 0.
  - A memread match at k < LOAD_READY cannot occur by construction; assert on it.
- fwd_sel is meaningful only while mem_busy=0; the EX data mux uses it every cycle.
- Counters saturate at all-ones, with no wrap:
  - stall_cnt increments per cycle with stall_if_id=1.
  - freeze_cnt increments per cycle with mem_busy=1.
  - flush_cnt increments per cycle with flush_if_id=1.
- Simultaneous stall and branch_taken: the stall wins and there is no flush.
- Simultaneous mem_busy with anything else: everything holds and no output pulses.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: the three counters are implemented as above.
- Undefined: no counter flops are built, stall_cnt/freeze_cnt/flush_cnt are tied to 0, and all other behaviour is unchanged.

Test Plan:
- ADD R1,R2,R3 then ADD R4,R1,R5 back-to-back (defaults) -> no stall; fwd_sel1=1 in the consumer's EX cycle.
- LW R1 then ADD R3,R1,R2 -> stall_if_id=bubble_id_ex=1 for exactly 1 cycle, then fwd_sel1=2; stall_cnt=1.
- ADD R1 then ADD R1 then SUB R6,R1,R1 -> fwd_sel1=fwd_sel2=1 (youngest writer wins), no stall.
- ADD R1 then BR R1 (id_src_early=1, DEPTH=3) -> 2 stall cycles; branch_taken flushes only on cycle 3; flush_cnt=1.
- LW R1 then consumer, with mem_busy high for 3 cycles during the stall -> entries frozen, stall_if_id=0 while busy, freeze_cnt=3, exactly 1 stall cycle counted after busy drops.
- ADD R0,R1,R2 then ADD R3,R0,R0 with R0_IS_ZERO=1 -> fwd_sel=0, no stall; async reset mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based stall / bubble / flush / forward-select controller for the WISC pipe.
// Performance counters are built only when HAZ_PERF_CNT_EN is defined; otherwise they read 0.

module pipe_hazard_ctrl_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic check_en_i,
    input  logic early_load_fwd_i
);

    // A load result must never be selected for forwarding before it is available.
    a_no_early_load_fwd: assert property (
        @(posedge clk) disable iff (!rst_n) check_en_i |-> !early_load_fwd_i
    );

endmodule

module pipe_hazard_ctrl #(
    parameter int REG_AW     = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int R0_IS_ZERO = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic              id_src_early,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic [2:0]        fwd_sel1,
    output logic [2:0]        fwd_sel2,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  freeze_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic              src1_used;
        logic              src2_used;
        logic [REG_AW-1:0] dst;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
    } entry_t;

    localparam entry_t ENTRY_NONE = entry_t'({$bits(entry_t){1'b0}});

    function automatic logic is_match(input entry_t e, input logic [REG_AW-1:0] s);
        logic r0_s;
        r0_s = (R0_IS_ZERO != 0) && (s == {REG_AW{1'b0}});
        return e.valid && e.regwrite && (e.dst == s) && !r0_s;
    endfunction

    // Returns {found, index} of the smallest set bit at or above kmin.
    function automatic logic [3:0] youngest(input logic [DEPTH-1:0] v, input int kmin);
        logic [3:0]       r;
        logic [DEPTH-1:0] t;
        r = 4'd0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            t = v >> k;
            if (t[0] && (k >= kmin)) begin
                r = {1'b1, 3'(k)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic src_stall(input logic used, input logic early,
                                       input logic [3:0] y, input logic [DEPTH-1:0] mr);
        logic [DEPTH-1:0] t;
        int               k;
        logic             r;
        k = int'(y[2:0]);
        t = mr >> y[2:0];
        if (!used || !y[3]) begin
            r = 1'b0;
        end else if (early) begin
            r = (k < DEPTH - 1);
        end else begin
            r = t[0] && (k + 1 < LOAD_READY);
        end
        return r;
    endfunction

    entry_t           entry_q [DEPTH];
    entry_t           entry0_d;
    entry_t           id_entry_s;
    logic             started_q;

    logic [DEPTH-1:0] m_id1_s, m_id2_s, m_ex1_s, m_ex2_s, mr_s;
    logic [3:0]       y_id1_s, y_id2_s, y_ex1_s, y_ex2_s;
    logic             stall_s, flush_s;
    logic [2:0]       fwd1_s, fwd2_s;
    logic             early_load_fwd_s;
    logic [DEPTH-1:0] t_ex1_s, t_ex2_s;

    for (genvar k = 0; k < DEPTH; k++) begin : g_match
        assign m_id1_s[k] = is_match(entry_q[k], id_src1);
        assign m_id2_s[k] = is_match(entry_q[k], id_src2);
        assign m_ex1_s[k] = is_match(entry_q[k], entry_q[0].src1);
        assign m_ex2_s[k] = is_match(entry_q[k], entry_q[0].src2);
        assign mr_s[k]    = entry_q[k].memread;
    end

    assign y_id1_s = youngest(m_id1_s, 0);
    assign y_id2_s = youngest(m_id2_s, 0);
    assign y_ex1_s = youngest(m_ex1_s, 1);
    assign y_ex2_s = youngest(m_ex2_s, 1);

    // Outputs are gated by started_q so they stay quiet through the first cycle out of reset.
    always_comb begin
        stall_s = started_q && id_valid && !mem_busy &&
                  (src_stall(id_src1_used, id_src_early, y_id1_s, mr_s) ||
                   src_stall(id_src2_used, id_src_early, y_id2_s, mr_s));
        flush_s = started_q && branch_taken && !stall_s && !mem_busy;
        if (started_q && entry_q[0].valid && entry_q[0].src1_used && y_ex1_s[3]) begin
            fwd1_s = y_ex1_s[2:0];
        end else begin
            fwd1_s = 3'd0;
        end
        if (started_q && entry_q[0].valid && entry_q[0].src2_used && y_ex2_s[3]) begin
            fwd2_s = y_ex2_s[2:0];
        end else begin
            fwd2_s = 3'd0;
        end
    end

    assign stall_if_id  = stall_s;
    assign bubble_id_ex = stall_s;
    assign flush_if_id  = flush_s;
    assign fwd_sel1     = fwd1_s;
    assign fwd_sel2     = fwd2_s;

    always_comb begin
        id_entry_s           = ENTRY_NONE;
        id_entry_s.valid     = 1'b1;
        id_entry_s.regwrite  = id_regwrite;
        id_entry_s.memread   = id_memread;
        id_entry_s.src1_used = id_src1_used;
        id_entry_s.src2_used = id_src2_used;
        id_entry_s.dst       = id_dst;
        id_entry_s.src1      = id_src1;
        id_entry_s.src2      = id_src2;
        if (mem_busy) begin
            entry0_d = entry_q[0];
        end else if (id_valid && !stall_s) begin
            entry0_d = id_entry_s;
        end else begin
            entry0_d = ENTRY_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q[0] <= ENTRY_NONE;
            started_q  <= 1'b0;
        end else begin
            entry_q[0] <= entry0_d;
            started_q  <= 1'b1;
        end
    end

    for (genvar k = 1; k < DEPTH; k++) begin : g_shift
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_q[k] <= ENTRY_NONE;
            end else if (mem_busy) begin
                entry_q[k] <= entry_q[k];
            end else begin
                entry_q[k] <= entry_q[k-1];
            end
        end
    end

    // Flags a forward of a load result from a stage where the data is not yet present.
    always_comb begin
        t_ex1_s = mr_s >> y_ex1_s[2:0];
        t_ex2_s = mr_s >> y_ex2_s[2:0];
        early_load_fwd_s =
            ((fwd1_s != 3'd0) && t_ex1_s[0] && (int'(fwd1_s) < LOAD_READY)) ||
            ((fwd2_s != 3'd0) && t_ex2_s[0] && (int'(fwd2_s) < LOAD_READY));
    end

    pipe_hazard_ctrl_chk u_chk (
        .clk              (clk),
        .rst_n            (rst_n),
        .check_en_i       (started_q && !mem_busy),
        .early_load_fwd_i (early_load_fwd_s)
    );

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (c != {CNT_W{1'b1}})) begin
            r = c + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = c;
        end
        return r;
    endfunction

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // stall/flush are already low while busy, so those counters hold during a freeze.
    always_comb begin
        stall_cnt_d  = sat_inc(stall_cnt_q, stall_s);
        freeze_cnt_d = sat_inc(freeze_cnt_q, mem_busy);
        flush_cnt_d  = sat_inc(flush_cnt_q, flush_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= {CNT_W{1'b0}};
            freeze_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    assign stall_cnt  = {CNT_W{1'b0}};
    assign freeze_cnt = {CNT_W{1'b0}};
    assign flush_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters; counter expectations follow HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_src1 = 4'd0, id_src2 = 4'd0, id_dst = 4'd0;
    logic        id_src1_used = 1'b0, id_src2_used = 1'b0, id_src_early = 1'b0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0;
    logic        branch_taken = 1'b0, mem_busy = 1'b0;
    logic        stall_if_id, bubble_id_ex, flush_if_id;
    logic [2:0]  fwd_sel1, fwd_sel2;
    logic [15:0] stall_cnt, freeze_cnt, flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

`ifdef HAZ_PERF_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_src_early(id_src_early), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input int st, input int fl, input int f1, input int f2);
        chk({tag, " stall"},  int'(stall_if_id),  st);
        chk({tag, " bubble"}, int'(bubble_id_ex), st);
        chk({tag, " flush"},  int'(flush_if_id),  fl);
        chk({tag, " fwd1"},   int'(fwd_sel1),     f1);
        chk({tag, " fwd2"},   int'(fwd_sel2),     f2);
    endtask

    task automatic chk_cnt(input string tag, input int st, input int fr, input int fl);
        chk({tag, " stall_cnt"},  int'(stall_cnt),  st * CNT_ON);
        chk({tag, " freeze_cnt"}, int'(freeze_cnt), fr * CNT_ON);
        chk({tag, " flush_cnt"},  int'(flush_cnt),  fl * CNT_ON);
    endtask

    // Wait for the falling edge, drive one decode slot, then settle before checking.
    task automatic op(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                      input logic u1, input logic u2, input logic e, input logic [3:0] d,
                      input logic rw, input logic mr, input logic br, input logic busy);
        @(negedge clk);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_src1_used = u1; id_src2_used = u2;
        id_src_early = e; id_dst = d; id_regwrite = rw; id_memread = mr;
        branch_taken = br; mem_busy = busy;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset, then the quiet first cycle, then a plain flush
        op(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("rst", 0, 0, 0, 0);
        chk_cnt("rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst flush", int'(flush_if_id), 0);
        op(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("br_plain", 0, 1, 0, 0);
        idle(1);

        // ADD R1,R2,R3 ; ADD R4,R1,R5
        op(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("n1", 0, 0, 0, 0);
        op(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("n2", 0, 0, 0, 0);
        idle(1);
        chk_out("n3", 0, 0, 1, 0);

        // LW R1 ; ADD R3,R1,R2
        op(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("l1", 0, 0, 0, 0);
        op(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("l2", 1, 0, 0, 0);
        op(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("l3", 0, 0, 0, 0);
        idle(1);
        chk_out("l4", 0, 0, 2, 0);
        chk_cnt("l4", 1, 0, 1);
        idle(3);

        // ADD R1 ; ADD R1 ; SUB R6,R1,R1
        op(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("a1", 0, 0, 0, 0);
        op(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("a2", 0, 0, 0, 0);
        op(1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("a3", 0, 0, 0, 0);
        idle(1);
        chk_out("a4", 0, 0, 1, 1);
        idle(3);

        // ADD R1 ; BR R1 taken (sources consumed in ID)
        op(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("b1", 0, 0, 0, 0);
        op(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("b2", 1, 0, 0, 0);
        op(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("b3", 1, 0, 0, 0);
        op(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("b4", 0, 1, 0, 0);
        idle(1);
        chk_out("b5", 0, 0, 0, 0);
        chk_cnt("b5", 3, 0, 2);
        idle(3);

        // LW R1 ; ADD R3,R1,R2 with a 3-cycle memory freeze before the stall resolves
        op(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("c1", 0, 0, 0, 0);
        op(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_out("c2", 0, 0, 0, 0);
        op(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_out("c3", 0, 0, 0, 0);
        op(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_out("c4", 0, 0, 0, 0);
        op(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("c5", 1, 0, 0, 0);
        chk_cnt("c5", 3, 3, 2);
        op(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("c6", 0, 0, 0, 0);
        idle(1);
        chk_out("c7", 0, 0, 2, 0);
        chk_cnt("c7", 4, 3, 2);
        idle(3);

        // R0 writers never match
        op(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("d1", 0, 0, 0, 0);
        op(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("d2", 0, 0, 0, 0);
        op(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("d3", 0, 0, 0, 0);
        op(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("d4", 0, 0, 0, 0);
        op(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("d5", 0, 0, 0, 0);

        // stall beats a simultaneous taken branch, then an async reset mid-cycle
        op(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_out("d6", 1, 0, 0, 0);
        chk_cnt("d6", 4, 3, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        chk_cnt("async_rst", 0, 0, 0);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
